// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA plot port between up to four pixel producers.
// A producer may lock the grant for atomic bursts; idle locks time out; off-screen pixels are dropped.
module vga_plot_arbiter #(
   parameter int N_REQ        = 3,
   parameter int X_MAX        = 159,
   parameter int Y_MAX        = 119,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ-1:0]   req_lock,
   input  logic [8*N_REQ-1:0] req_x,
   input  logic [7*N_REQ-1:0] req_y,
   input  logic [3*N_REQ-1:0] req_colour,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         vga_x,
   output logic [6:0]         vga_y,
   output logic [2:0]         vga_colour,
   output logic               vga_plot,
   output logic [1:0]         grant_id,
   output logic [7:0]         drop_cnt,
   output logic               busy
);

   localparam int IW = (N_REQ > 2) ? 2 : 1;

   // Handshake: a pixel moves when req_valid[i] & req_ready[i]; ready never waits on the
   // registered outputs, and a requester holding valid keeps its pixel stable until ready.
   typedef enum logic {ST_OPEN, ST_OWNED} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   last_grant_q, last_grant_d;
   logic [7:0]      idle_q, idle_d;

   logic [IW-1:0]   sel;
   logic [IW-1:0]   cand;
   logic            found;
   logic            xfer;
   logic            sel_lock;
   logic [7:0]      sel_x;
   logic [6:0]      sel_y;
   logic [2:0]      sel_colour;
   logic            visible;

   // State register
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q      <= ST_OPEN;
         owner_q      <= '0;
         last_grant_q <= IW'(N_REQ - 1);
         idle_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         idle_q       <= idle_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      idle_d       = idle_q;
      if (xfer) begin
         last_grant_d = sel;
         idle_d       = '0;
         if (sel_lock) begin
            state_d = ST_OWNED;
            owner_d = sel;
         end else begin
            state_d = ST_OPEN;
         end
      end else if (state_q == ST_OWNED) begin
         // Without a transfer while owned, the owner is idle this cycle.
         if (idle_q == 8'(LOCK_TIMEOUT - 1)) begin
            state_d = ST_OPEN;
            idle_d  = '0;
         end else begin
            idle_d = idle_q + 8'd1;
         end
      end else begin
         idle_d = '0;
      end
   end

   // Output logic: grant selection and ready generation
   always_comb begin
      sel       = owner_q;
      cand      = '0;
      found     = 1'b0;
      req_ready = '0;
      if (!rstn) begin
         if (state_q == ST_OWNED) begin
            req_ready[owner_q] = req_valid[owner_q];
         end else begin
            for (int k = 1; k <= N_REQ; k++) begin
               cand = IW'((int'(last_grant_q) + k) % N_REQ);
               if (!found && req_valid[cand]) begin
                  found = 1'b1;
                  sel   = cand;
               end
            end
            req_ready[sel] = found;
         end
      end
   end

   assign xfer     = |(req_valid & req_ready);
   assign sel_lock = req_lock[sel];
   assign busy     = (state_q == ST_OWNED) | (|req_valid);

   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel == IW'(i)) begin
            sel_x      = req_x[8*i +: 8];
            sel_y      = req_y[7*i +: 7];
            sel_colour = req_colour[3*i +: 3];
         end
      end
   end

   assign visible = (int'(sel_x) <= X_MAX) && (int'(sel_y) <= Y_MAX);

   // Plot port registers; clipped pixels are consumed but only counted.
   always_ff @(posedge clk) begin
      if (rstn) begin
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         grant_id   <= '0;
         drop_cnt   <= '0;
      end else begin
         vga_plot <= xfer & visible;
         if (xfer && visible) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            grant_id   <= 2'(sel);
         end
         if (xfer && !visible && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: table-driven arbitration vectors plus hand-written
// reset, clipping and lock corner sequences, checked through an expected-output queue.
module tb_vga_plot_arbiter;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N-1:0]   req_valid, req_lock, req_ready;
   logic [8*N-1:0] req_x;
   logic [7*N-1:0] req_y;
   logic [3*N-1:0] req_colour;
   logic [7:0]     vga_x;
   logic [6:0]     vga_y;
   logic [2:0]     vga_colour;
   logic           vga_plot;
   logic [1:0]     grant_id;
   logic [7:0]     drop_cnt;
   logic           busy;

   vga_plot_arbiter #(.N_REQ(N), .X_MAX(159), .Y_MAX(119), .LOCK_TIMEOUT(16)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_lock(req_lock),
      .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .grant_id(grant_id), .drop_cnt(drop_cnt), .busy(busy)
   );

   // Clock
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic [N-1:0] r;
      logic         p;
      logic [1:0]   g;
   } vec_t;

   vec_t        vecs[$];
   logic [28:0] exp_q[$];
   logic [28:0] mon_e;
   int          errors = 0;
   int          checks = 0;

   logic [7:0]  lx[N];
   logic [6:0]  ly[N];
   logic [2:0]  lc[N];
   logic [7:0]  last_x;
   logic [6:0]  last_y;
   logic [2:0]  last_c;
   logic [1:0]  last_g;
   logic [7:0]  exp_drop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic [N-1:0] v, input logic [N-1:0] l,
                               input logic [N-1:0] r, input logic p, input logic [1:0] g);
      vec_t e;
      e.v = v; e.l = l; e.r = r; e.p = p; e.g = g;
      vecs.push_back(e);
   endfunction

   task automatic rand_lane(input int i);
      lx[i] = 8'($urandom_range(0, 159));
      ly[i] = 7'($urandom_range(0, 119));
      lc[i] = 3'($urandom_range(0, 7));
   endtask

   // Scoreboard: each applied cycle pushes the expected registered outputs for the next cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("vga_out{plot,x,y,colour,gid,drop}",
               32'({vga_plot, vga_x, vga_y, vga_colour, grant_id, drop_cnt}), 32'(mon_e));
      end
   end

   // Driver: apply inputs just after negedge, check ready, push expectation, advance a cycle.
   task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] r,
                        input logic p, input logic [1:0] g);
      #1;
      req_valid = v;
      req_lock  = l;
      for (int i = 0; i < N; i++) begin
         req_x[8*i +: 8]      = lx[i];
         req_y[7*i +: 7]      = ly[i];
         req_colour[3*i +: 3] = lc[i];
      end
      #1;
      check("req_ready", 32'(req_ready), 32'(r));
      if (p) begin
         last_x = lx[g]; last_y = ly[g]; last_c = lc[g]; last_g = g;
      end else if (r != '0 && exp_drop != 8'hFF) begin
         exp_drop = exp_drop + 8'd1;
      end
      exp_q.push_back({p, last_x, last_y, last_c, last_g, exp_drop});
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (r[i]) rand_lane(i);
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] r,
                        input logic p, input logic [1:0] g);
      @(negedge clk);
      apply(v, l, r, p, g);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Round robin, then lock burst
      for (int k = 0; k < 2; k++) begin
         add(3'b111, 3'b000, 3'b100, 1'b1, 2'd2);
         add(3'b111, 3'b000, 3'b001, 1'b1, 2'd0);
         add(3'b111, 3'b000, 3'b010, 1'b1, 2'd1);
      end
      add(3'b010, 3'b010, 3'b010, 1'b1, 2'd1);
      for (int k = 0; k < 6; k++) add(3'b111, 3'b010, 3'b010, 1'b1, 2'd1);
      add(3'b111, 3'b000, 3'b010, 1'b1, 2'd1);
      add(3'b111, 3'b000, 3'b100, 1'b1, 2'd2);
      add(3'b111, 3'b000, 3'b001, 1'b1, 2'd0);
      // Owner drops valid briefly and returns before the timeout
      add(3'b100, 3'b100, 3'b100, 1'b1, 2'd2);
      for (int k = 0; k < 3; k++) add(3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
      add(3'b101, 3'b000, 3'b100, 1'b1, 2'd2);
      add(3'b001, 3'b000, 3'b001, 1'b1, 2'd0);
      // Lock timeout: 16 idle owner cycles, requester 0 ready on the 17th
      add(3'b100, 3'b100, 3'b100, 1'b1, 2'd2);
      for (int k = 0; k < 16; k++) add(3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
      add(3'b001, 3'b000, 3'b001, 1'b1, 2'd0);
      // Owner returns on the cycle the timeout would fire: lock survives
      add(3'b100, 3'b100, 3'b100, 1'b1, 2'd2);
      for (int k = 0; k < 15; k++) add(3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
      add(3'b101, 3'b100, 3'b100, 1'b1, 2'd2);
      add(3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
      add(3'b101, 3'b000, 3'b100, 1'b1, 2'd2);
      add(3'b001, 3'b000, 3'b001, 1'b1, 2'd0);

      // Reset with every requester valid
      rstn = 1'b1;
      req_valid = '1;
      req_lock = '0;
      for (int i = 0; i < N; i++) rand_lane(i);
      req_x = {lx[2], lx[1], lx[0]};
      req_y = {ly[2], ly[1], ly[0]};
      req_colour = {lc[2], lc[1], lc[0]};
      last_x = '0; last_y = '0; last_c = '0; last_g = '0; exp_drop = '0;
      repeat (2) begin
         @(negedge clk);
         check("reset req_ready", 32'(req_ready), 32'd0);
         check("reset outputs", 32'({vga_plot, vga_x, vga_y, vga_colour, grant_id, drop_cnt}), 32'd0);
      end
      rstn = 1'b0;
      apply(3'b111, 3'b000, 3'b001, 1'b1, 2'd0);

      // Single pixel from requester 1, then an empty cycle
      lx[1] = 8'd80; ly[1] = 7'd60; lc[1] = 3'd5;
      drive(3'b010, 3'b000, 3'b010, 1'b1, 2'd1);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 2'd0);
      check("busy idle open", 32'(busy), 32'd0);

      foreach (vecs[i]) drive(vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].p, vecs[i].g);

      // Clipping boundaries on requester 0
      lx[0] = 8'd160; ly[0] = 7'd10;  drive(3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
      lx[0] = 8'd5;   ly[0] = 7'd120; drive(3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
      lx[0] = 8'd159; ly[0] = 7'd119; drive(3'b001, 3'b000, 3'b001, 1'b1, 2'd0);
      for (int k = 0; k < 300; k++) begin
         if (k % 2 == 0) begin
            lx[0] = 8'($urandom_range(160, 255)); ly[0] = 7'($urandom_range(0, 127));
         end else begin
            lx[0] = 8'($urandom_range(0, 255));   ly[0] = 7'($urandom_range(120, 127));
         end
         drive(3'b001, 3'b000, 3'b001, 1'b0, 2'd0);
      end
      @(negedge clk);
      check("drop_cnt saturated", 32'(drop_cnt), 32'd255);

      // Reset while a lock is held
      apply(3'b100, 3'b100, 3'b100, 1'b1, 2'd2);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 2'd0);
      check("busy while owned", 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      rstn = 1'b1;
      req_valid = '1;
      req_lock = '1;
      #1;
      check("mid reset req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("mid reset outputs", 32'({vga_plot, vga_x, vga_y, vga_colour, grant_id, drop_cnt}), 32'd0);
      last_x = '0; last_y = '0; last_c = '0; last_g = '0; exp_drop = '0;
      rstn = 1'b0;
      apply(3'b111, 3'b000, 3'b001, 1'b1, 2'd0);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 2'd0);
      check("busy after reset", 32'(busy), 32'd0);

      repeat (2) @(negedge clk);
      #1;
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA framebuffer plot port (vga_x/vga_y/vga_colour/vga_plot) between up to four pixel producers: screen-clear engine, circle drawer, and future shape engines. Uses round-robin arbitration with an optional lock so that a producer can emit an atomic burst, such as the eight octant points of one circle step. Registers one pixel per cycle onto the plot port and drops off-screen pixels. Sits between the drawing engines and the VGA adapter.

## Interface
- N_REQ, 3, number of requesters (2..4)
- X_MAX, 159, largest visible x
- Y_MAX, 119, largest visible y
- LOCK_TIMEOUT, 16, consecutive idle cycles before a lock is forcibly released (1..255)

- clk  in  1  single clock, all logic on posedge
- rstn  in  1  reset; synchronous, active-high (asserted = 1)
- req_valid  in  N_REQ  requester i has a pixel
- req_lock  in  N_REQ  hold grant after this pixel
- req_x  in  8*N_REQ  x of requester i at bits [8i+7:8i]
- req_y  in  7*N_REQ  y of requester i at bits [7i+6:7i]
- req_colour  in  3*N_REQ  colour of requester i
- req_ready  out  N_REQ  combinational accept; transfer = valid & ready
- vga_x  out  8  registered pixel x
- vga_y  out  7  registered pixel y
- vga_colour  out  3  registered colour
- vga_plot  out  1  registered write strobe
- grant_id  out  2  index of requester whose pixel is on the port
- drop_cnt  out  8  saturating count of clipped pixels
- busy  out  1  owned | (|req_valid)

## Operation
- State: OPEN (no owner) or OWNED(owner); last_grant register; 8-bit idle counter.
- OPEN: winner = first valid requester scanning last_grant+1, +2, … mod N_REQ. req_ready is high only for the winner. With no valid requesters, all ready bits are 0.
- OWNED: req_ready[owner] = req_valid[owner]; all other ready bits are 0.
- At most one transfer per cycle. On each transfer:
  - last_grant ← index.
  - If req_lock = 1, state ← OWNED(index).
  - If req_lock = 0, state ← OPEN.
- Idle counter:
  - Clears on every transfer and whenever the state is OPEN.
  - Increments each OWNED cycle in which req_valid[owner] = 0.
  - Reaching LOCK_TIMEOUT forces state ← OPEN at the end of that cycle.
- Clipping: a transfer with x > X_MAX or y > Y_MAX is accepted but does not plot. vga_plot is 0 the next cycle and drop_cnt increments, saturating at 255. Comparisons are unsigned.
- Output registers:
  - On a visible transfer, vga_x, vga_y, vga_colour and grant_id load next cycle and vga_plot = 1.
  - Otherwise vga_plot = 0 and the other outputs hold their values.
- A requester that holds valid keeps x/y/colour stable until it sees ready.

## Timing
- Reset values: vga_x 0, vga_y 0, vga_colour 0, vga_plot 0, grant_id 0, drop_cnt 0.
- After reset: state OPEN, last_grant = N_REQ-1 (requester 0 has first priority), idle counter 0.
- Reset mid-operation: any same-cycle transfer is discarded, vga_plot = 0 next cycle, lock is cleared.
- Latency: valid & ready in cycle T gives vga_plot = 1 in cycle T+1.
- Throughput: 1 pixel/cycle sustained. A locked owner, or a lone requester, may transfer every cycle.
- Owner drops valid and then reasserts it before the timeout: no gap to other requesters. The counter clears on its next transfer.
- Owner's valid returns in the same cycle the counter would reach LOCK_TIMEOUT: the transfer wins and the lock persists.
- Lock timeout: last locked transfer at cycle T, with owner idle from T+1. Release happens at the end of T+LOCK_TIMEOUT. Another requester can first be ready at T+LOCK_TIMEOUT+1.

## Test plan
- Reset: hold rstn=1 for 2 cycles with all req_valid=1 → all outputs 0 and req_ready=0. The first cycle after release grants requester 0.
- Single pixel: req1 valid (80,60,colour 5), others idle → req_ready=3'b010 in cycle T. At T+1: vga_plot=1, vga_x=80, vga_y=60, vga_colour=5, grant_id=1. At T+2: vga_plot=0.
- Round-robin: all three valid continuously, lock=0 → grant_id sequence 0,1,2,0,1,2 with vga_plot=1 every cycle.
- Lock burst: req1 sends 8 pixels with lock=1 on the first 7 and lock=0 on the 8th; req0 and req2 are valid throughout → eight consecutive grants to 1, then 2, then 0.
- Lock timeout (LOCK_TIMEOUT=16): req2 makes a locked transfer at cycle T then drops valid; req0 is valid from T+1 → req0 is first ready at T+17, and req_ready[0]=0 for T+1..T+16.
- Clipping: req0 sends (160,10), then (5,120), then (159,119) → first two give vga_plot=0 and drop_cnt=1 then 2; the third plots. Then 300 clipped pixels → drop_cnt=255.
